// File: rtl/bmd_axist_mem_arb_pkg.sv
// bmd_axist_mem_arb_pkg: shared FSM encoding and widths for the BMD register-file arbiter
package bmd_axist_mem_arb_pkg;
    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        RD_SETUP = 6'b000010,
        RD_CAP   = 6'b000100,
        WR_ISSUE = 6'b001000,
        WR_WAIT  = 6'b010000,
        DONE     = 6'b100000
    } state_t;
    localparam int MEM_WR_BE_W   = 8;
    localparam int RD_PIPE_DEPTH = 2;
endpackage

// File: rtl/bmd_axist_rr_arb2.sv
// bmd_axist_rr_arb2: 2-way round-robin grant, fixed port-0 priority under BMD_MEM_ARB_FIXED_PRIO_EN
module bmd_axist_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
`ifdef BMD_MEM_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = &{clk, rst_n, advance};
    always_comb gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    logic rr_ptr;
    always_comb gnt = (&req) ? (rr_ptr ? 2'b10 : 2'b01) : req;
    // pointer moves to whichever index lost (or was idle) on this grant
    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr <= 1'b0;
        else if (advance) rr_ptr <= gnt[0];
    end
`endif
endmodule

// File: rtl/bmd_axist_ep_mem_arb.sv
// bmd_axist_ep_mem_arb: two-port sequencer for the BMD register file; BMD_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module bmd_axist_ep_mem_arb
    import bmd_axist_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int WR_TIMEOUT = 64,
    parameter int TO_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic                   req0_we,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [3:0]             req0_be,
    input  logic [31:0]            req0_wdata,
    output logic                   req0_done,
    output logic [31:0]            req0_rdata,
    input  logic                   req1_valid,
    input  logic                   req1_we,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [3:0]             req1_be,
    input  logic [31:0]            req1_wdata,
    output logic                   req1_done,
    output logic [31:0]            req1_rdata,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [3:0]             mem_rd_be_o,
    output logic [MEM_WR_BE_W-1:0] mem_wr_be_o,
    output logic [31:0]            mem_wr_data_o,
    output logic                   mem_wr_en_o,
    input  logic [31:0]            mem_rd_data_i,
    input  logic                   mem_wr_busy_i,
    output logic                   arb_busy_o,
    output logic                   arb_owner_o,
    output logic                   wr_timeout_o
);
    state_t              state, state_nx;
    logic [1:0]          gnt;
    logic                grant, sel, sel_we, to_hit, done;
    logic [ADDR_W-1:0]   sel_addr;
    logic [3:0]          sel_be;
    logic [31:0]         sel_wdata;
    logic [TO_CNT_W-1:0] to_cnt;

    assign grant     = (state == IDLE) && (req0_valid || req1_valid);
    assign sel       = gnt[1];
    assign sel_we    = sel ? req1_we : req0_we;
    assign sel_addr  = sel ? req1_addr : req0_addr;
    assign sel_be    = sel ? req1_be : req0_be;
    assign sel_wdata = sel ? req1_wdata : req0_wdata;
    assign to_hit    = to_cnt == TO_CNT_W'(WR_TIMEOUT - 1);

    bmd_axist_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (grant),
        .gnt     (gnt)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = grant ? (sel_we ? WR_ISSUE : RD_SETUP) : IDLE;
            RD_SETUP: state_nx = RD_CAP;
            RD_CAP:   state_nx = DONE;
            WR_ISSUE: state_nx = WR_WAIT;
            WR_WAIT:  state_nx = (!mem_wr_busy_i || to_hit) ? DONE : WR_WAIT;
            default:  state_nx = IDLE;
        endcase
    end

    // strobes are gated by rst_n so an in-flight access is dropped in the reset cycle itself
    assign done        = (state == DONE) && rst_n;
    assign req0_done   = done && !arb_owner_o;
    assign req1_done   = done && arb_owner_o;
    assign mem_wr_en_o = (state == WR_ISSUE) && rst_n;
    assign arb_busy_o  = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            arb_owner_o   <= 1'b0;
            mem_addr_o    <= '0;
            mem_rd_be_o   <= '0;
            mem_wr_be_o   <= '0;
            mem_wr_data_o <= '0;
            req0_rdata    <= '0;
            req1_rdata    <= '0;
            to_cnt        <= '0;
            wr_timeout_o  <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                arb_owner_o   <= sel;
                mem_addr_o    <= sel_addr;
                mem_rd_be_o   <= sel_we ? 4'h0 : sel_be;
                mem_wr_be_o   <= {{(MEM_WR_BE_W-4){1'b0}}, sel_we ? sel_be : 4'h0};
                mem_wr_data_o <= sel_wdata;
            end
            if (state == DONE) begin
                mem_rd_be_o <= '0;
                mem_wr_be_o <= '0;
            end
            if (state == RD_CAP && !arb_owner_o) req0_rdata <= mem_rd_data_i;
            if (state == RD_CAP && arb_owner_o) req1_rdata <= mem_rd_data_i;
            to_cnt <= (state == WR_WAIT) ? to_cnt + 1'b1 : '0;
            if (state == WR_WAIT && mem_wr_busy_i && to_hit) wr_timeout_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bmd_axist_ep_mem_arb.sv
// tb_bmd_axist_ep_mem_arb: directed vector bench for the register-file arbiter
module tb_bmd_axist_ep_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [6:0]  req0_addr, req1_addr;
    logic [3:0]  req0_be, req1_be;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_done, req1_done;
    logic [31:0] req0_rdata, req1_rdata;
    logic [6:0]  mem_addr_o;
    logic [3:0]  mem_rd_be_o;
    logic [7:0]  mem_wr_be_o;
    logic [31:0] mem_wr_data_o, mem_rd_data_i;
    logic        mem_wr_en_o, mem_wr_busy_i, arb_busy_o, arb_owner_o, wr_timeout_o;

    logic [31:0] mem [128];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          busy_len = 0;
    int          busy_left = 0;
    logic        busy_stuck = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bmd_axist_ep_mem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_be(req0_be),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_be(req1_be),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .mem_addr_o(mem_addr_o), .mem_rd_be_o(mem_rd_be_o), .mem_wr_be_o(mem_wr_be_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_en_o(mem_wr_en_o), .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_busy_i(mem_wr_busy_i), .arb_busy_o(arb_busy_o), .arb_owner_o(arb_owner_o),
        .wr_timeout_o(wr_timeout_o)
    );

    // register-file model: combinational read, byte-enabled write, busy for busy_len cycles after a write
    assign mem_rd_data_i = mem[mem_addr_o];
    assign mem_wr_busy_i = busy_stuck || (busy_left > 0);
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr_en_o)
            for (int b = 0; b < 4; b++)
                if (mem_wr_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wr_data_o[8*b +: 8];
        busy_left <= mem_wr_en_o ? busy_len : (busy_left > 0 ? busy_left - 1 : 0);
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [6:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          busy;
        int          lat;
        logic [31:0] rdata;
    } vec_t;
    vec_t v[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic port, input logic we, input logic [6:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        if (port) begin
            req1_we = we; req1_addr = a; req1_be = be; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_we = we; req0_addr = a; req0_be = be; req0_wdata = d; req0_valid = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, {26'd0, req0_done, req1_done, mem_wr_en_o, arb_busy_o, arb_owner_o, wr_timeout_o}, 0);
        chk({name, "_mem"}, {13'd0, mem_addr_o, mem_rd_be_o, mem_wr_be_o}, 0);
        chk({name, "_wdata"}, mem_wr_data_o, 0);
        chk({name, "_rdata"}, req0_rdata | req1_rdata, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        int   lat, wr_pulses;
        logic addr_ok, other, seen;
        busy_len = t.busy;
        drive(t.port, t.we, t.addr, t.be, t.wdata);
        lat = 0; wr_pulses = 0; addr_ok = 1'b1; other = 1'b0; seen = 1'b0;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (lat == 1 && !t.we) begin
                chk($sformatf("v%0d_rd_addr", idx), {25'd0, mem_addr_o}, {25'd0, t.addr});
                chk($sformatf("v%0d_rd_be", idx), {28'd0, mem_rd_be_o}, {28'd0, t.be});
            end
            if (mem_wr_en_o) begin
                wr_pulses++;
                chk($sformatf("v%0d_wr_be", idx), {24'd0, mem_wr_be_o}, {28'd0, t.be});
                chk($sformatf("v%0d_wr_data", idx), mem_wr_data_o, t.wdata);
            end
            if (t.we && mem_addr_o != t.addr) addr_ok = 1'b0;
            if (t.port ? req0_done : req1_done) other = 1'b1;
            seen = t.port ? req1_done : req0_done;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, t.lat);
        chk($sformatf("v%0d_rdata", idx), t.port ? req1_rdata : req0_rdata, t.rdata);
        chk($sformatf("v%0d_other_done", idx), {31'd0, other}, 0);
        if (t.we) begin
            chk($sformatf("v%0d_wr_pulses", idx), wr_pulses, 1);
            chk($sformatf("v%0d_addr_stable", idx), {31'd0, addr_ok}, 1);
        end
        tick();
    endtask

    initial begin
        int          n, cyc, last, lat, wr_pulses, ovl, d0c, d1c;
        logic [3:0]  seq;
        logic        bad;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_be = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_be = 0; req1_wdata = 0;
        v[0] = '{1'b0, 1'b0, 7'h05, 4'hF, 32'h0,          0, 3, 32'hA5A5_0001};
        v[1] = '{1'b1, 1'b1, 7'h10, 4'h3, 32'h1234_5678,  3, 6, 32'h0};
        v[2] = '{1'b1, 1'b0, 7'h10, 4'hF, 32'h0,          0, 3, 32'h0000_5678};
        v[3] = '{1'b0, 1'b1, 7'h7F, 4'hC, 32'hFFFF_0000,  0, 3, 32'hA5A5_0001};
        v[4] = '{1'b0, 1'b0, 7'h7F, 4'hF, 32'h0,          0, 3, 32'hFFFF_BEEF};
        v[5] = '{1'b1, 1'b0, 7'h00, 4'h1, 32'h0,          0, 3, 32'h0BAD_F00D};
        tick(); tick();
        preload(7'h05, 32'hA5A5_0001);
        preload(7'h10, 32'h0);
        preload(7'h7F, 32'hDEAD_BEEF);
        preload(7'h00, 32'h0BAD_F00D);
        preload(7'h01, 32'h1111_1111);
        preload(7'h02, 32'h2222_2222);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, v[i]);
        chk("no_timeout", {31'd0, wr_timeout_o}, 0);

        // both ports read continuously
        drive(1'b0, 1'b0, 7'h01, 4'hF, 32'h0);
        drive(1'b1, 1'b0, 7'h02, 4'hF, 32'h0);
        n = 0; cyc = 0; last = 0; seq = '0;
        while (n < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (req0_done || req1_done) begin
                seq[n] = req1_done;
                if (n > 0) chk($sformatf("alt_gap%0d", n), cyc - last, 4);
                last = cyc;
                n++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("alt_count", n, 4);
        chk("alt_rdata0", req0_rdata, 32'h1111_1111);
`ifdef BMD_MEM_ARB_FIXED_PRIO_EN
        chk("alt_seq", {28'd0, seq}, 32'h0);
        chk("alt_rdata1", req1_rdata, 32'h0BAD_F00D);
`else
        chk("alt_seq", {28'd0, seq}, 32'hA);
        chk("alt_rdata1", req1_rdata, 32'h2222_2222);
`endif

        // stuck busy -> watchdog abort
        busy_len = 0;
        busy_stuck = 1'b1;
        drive(1'b0, 1'b1, 7'h03, 4'hF, 32'h5555_5555);
        lat = 0;
        while (!req0_done && lat < 200) begin
            tick();
            lat++;
        end
        chk("to_latency", lat, 66);
        chk("to_flag_at_done", {31'd0, wr_timeout_o}, 1);
        req0_valid = 1'b0;
        busy_stuck = 1'b0;
        repeat (3) tick();
        chk("to_sticky", {31'd0, wr_timeout_o}, 1);

        // reset during WR_WAIT
        busy_stuck = 1'b1;
        drive(1'b1, 1'b1, 7'h20, 4'hF, 32'h7777_8888);
        repeat (3) tick();
        chk("rst_pre_busy", {31'd0, arb_busy_o}, 1);
        chk("rst_pre_done", {30'd0, req0_done, req1_done}, 0);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid");
        busy_stuck = 1'b0;
        rst_n = 1'b1;
        lat = 0; wr_pulses = 0; bad = 1'b0;
        while (!req1_done && lat < 20) begin
            tick();
            lat++;
            if (mem_wr_en_o) wr_pulses++;
            if (req0_done) bad = 1'b1;
        end
        req1_valid = 1'b0;
        tick();
        chk("rst_retry_lat", lat, 3);
        chk("rst_retry_wr", wr_pulses, 1);
        chk("rst_retry_other", {31'd0, bad}, 0);

        // read-after-write across ports
        busy_len = 1;
        drive(1'b0, 1'b1, 7'h30, 4'hF, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 7'h30, 4'hF, 32'h0);
        cyc = 0; ovl = 0; d0c = 0; d1c = 0; wr_pulses = 0;
        while ((d0c == 0 || d1c == 0) && cyc < 40) begin
            tick();
            cyc++;
            if (mem_wr_en_o) wr_pulses++;
            if (mem_wr_en_o && mem_rd_be_o != 0) ovl++;
            if (req0_done) begin d0c = cyc; req0_valid = 1'b0; end
            if (req1_done) begin d1c = cyc; req1_valid = 1'b0; end
        end
        tick();
        chk("raw_both_done", {30'd0, d0c != 0, d1c != 0}, 3);
        chk("raw_order", {31'd0, d0c < d1c}, 1);
        chk("raw_rdata", req1_rdata, 32'hCAFE_F00D);
        chk("raw_wr_pulses", wr_pulses, 1);
        chk("raw_overlap", ovl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
